// File: rtl/flow_ctrl.sv
// rtl/flow_ctrl.sv - pipeline flow controller: hazard/jump/trap/memory-wait/MDU stall
// and flush commands for PC and inter-stage registers, with perf counters.
module flow_ctrl #(
  parameter int MDU_TIMEOUT    = 64,
  parameter int FLOW_WIDTH     = 2,
  parameter int REG_ADDR_WIDTH = 5
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      trap_req_i,
  input  logic                      mem_stall_i,
  input  logic                      jump_taken_i,
  input  logic                      id_ex_mem_rd_i,
  input  logic [REG_ADDR_WIDTH-1:0] id_ex_rd_adder_i,
  input  logic [REG_ADDR_WIDTH-1:0] if_id_rs1_adder_i,
  input  logic [REG_ADDR_WIDTH-1:0] if_id_rs2_adder_i,
  input  logic                      rs1_used_i,
  input  logic                      rs2_used_i,
  input  logic                      mdu_start_i,
  input  logic                      mdu_done_i,
  output logic [FLOW_WIDTH-1:0]     flow_pc_o,
  output logic [FLOW_WIDTH-1:0]     flow_if_id_o,
  output logic [FLOW_WIDTH-1:0]     flow_id_ex_o,
  output logic [FLOW_WIDTH-1:0]     flow_ex_mem_o,
  output logic [FLOW_WIDTH-1:0]     flow_mem_wb_o,
  output logic                      mdu_kill_o,
  output logic [31:0]               stall_cnt_o,
  output logic [31:0]               flush_cnt_o
);

  localparam logic [FLOW_WIDTH-1:0] FLOW_WORK    = FLOW_WIDTH'(0);
  localparam logic [FLOW_WIDTH-1:0] FLOW_STOP    = FLOW_WIDTH'(1);
  localparam logic [FLOW_WIDTH-1:0] FLOW_REFRESH = FLOW_WIDTH'(2);
  localparam logic [7:0]            WAIT_LAST    = 8'(MDU_TIMEOUT - 1);

  typedef enum logic {ST_RUN, ST_MDU_WAIT} state_t;

  state_t      r_state;
  state_t      w_state_next;
  logic        r_done_pend;
  logic [7:0]  r_wait_cnt;
  logic [31:0] r_stall_cnt;
  logic [31:0] r_flush_cnt;

  logic w_in_wait;
  logic w_done_any;
  logic w_timeout;
  logic w_load_use;
  logic w_set_pend;
  logic w_clr_wait;
  logic w_flush_inc;

  assign w_in_wait  = (r_state == ST_MDU_WAIT);
  assign w_done_any = r_done_pend | mdu_done_i;
  assign w_timeout  = w_in_wait && (r_wait_cnt == WAIT_LAST) && !w_done_any;
  assign w_load_use = id_ex_mem_rd_i && (id_ex_rd_adder_i != '0) &&
                      ((rs1_used_i && (if_id_rs1_adder_i == id_ex_rd_adder_i)) ||
                       (rs2_used_i && (if_id_rs2_adder_i == id_ex_rd_adder_i)));

  always_comb begin
    flow_pc_o     = FLOW_WORK;
    flow_if_id_o  = FLOW_WORK;
    flow_id_ex_o  = FLOW_WORK;
    flow_ex_mem_o = FLOW_WORK;
    flow_mem_wb_o = FLOW_WORK;
    mdu_kill_o    = 1'b0;
    w_state_next  = r_state;
    w_set_pend    = 1'b0;
    w_clr_wait    = 1'b0;
    w_flush_inc   = 1'b0;
    if (trap_req_i) begin
      flow_if_id_o  = FLOW_REFRESH;
      flow_id_ex_o  = FLOW_REFRESH;
      flow_ex_mem_o = FLOW_REFRESH;
      w_flush_inc   = 1'b1;
      if (w_in_wait) begin
        mdu_kill_o   = 1'b1;
        w_state_next = ST_RUN;
      end
    end else if (mem_stall_i) begin
      flow_pc_o     = FLOW_STOP;
      flow_if_id_o  = FLOW_STOP;
      flow_id_ex_o  = FLOW_STOP;
      flow_ex_mem_o = FLOW_STOP;
      flow_mem_wb_o = FLOW_REFRESH;
      // a done pulse hidden behind the stall is remembered for the next free cycle
      w_set_pend    = w_in_wait && mdu_done_i;
      if (w_timeout) begin
        mdu_kill_o   = 1'b1;
        w_state_next = ST_RUN;
      end
    end else if (w_in_wait && !w_done_any) begin
      flow_pc_o     = FLOW_STOP;
      flow_if_id_o  = FLOW_STOP;
      flow_id_ex_o  = FLOW_STOP;
      flow_ex_mem_o = FLOW_REFRESH;
      if (w_timeout) begin
        mdu_kill_o   = 1'b1;
        w_state_next = ST_RUN;
      end
    end else if (w_in_wait) begin
      w_state_next = ST_RUN;
    end else if (jump_taken_i) begin
      flow_if_id_o = FLOW_REFRESH;
      flow_id_ex_o = FLOW_REFRESH;
      w_flush_inc  = 1'b1;
    end else if (mdu_start_i) begin
      flow_pc_o     = FLOW_STOP;
      flow_if_id_o  = FLOW_STOP;
      flow_id_ex_o  = FLOW_STOP;
      flow_ex_mem_o = FLOW_REFRESH;
      w_state_next  = ST_MDU_WAIT;
      w_clr_wait    = 1'b1;
    end else if (w_load_use) begin
      flow_pc_o    = FLOW_STOP;
      flow_if_id_o = FLOW_STOP;
      flow_id_ex_o = FLOW_REFRESH;
    end
    if (rst) begin
      flow_pc_o     = FLOW_REFRESH;
      flow_if_id_o  = FLOW_REFRESH;
      flow_id_ex_o  = FLOW_REFRESH;
      flow_ex_mem_o = FLOW_REFRESH;
      flow_mem_wb_o = FLOW_REFRESH;
      mdu_kill_o    = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state     <= ST_RUN;
      r_done_pend <= 1'b0;
      r_wait_cnt  <= 8'd0;
      r_stall_cnt <= 32'd0;
      r_flush_cnt <= 32'd0;
    end else begin
      r_state <= w_state_next;
      if (w_state_next == ST_RUN) begin
        r_done_pend <= 1'b0;
      end else if (w_set_pend) begin
        r_done_pend <= 1'b1;
      end
      if (w_clr_wait) begin
        r_wait_cnt <= 8'd0;
      end else if (w_in_wait) begin
        r_wait_cnt <= r_wait_cnt + 8'd1;
      end
      if (flow_pc_o != FLOW_WORK) begin
        r_stall_cnt <= r_stall_cnt + 32'd1;
      end
      if (w_flush_inc) begin
        r_flush_cnt <= r_flush_cnt + 32'd1;
      end
    end
  end

  assign stall_cnt_o = r_stall_cnt;
  assign flush_cnt_o = r_flush_cnt;

endmodule
